// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the data-memory responder: MMIO select bit, register offsets and
// TX_STATUS field positions.
package dmem_mmio_responder_pkg;

   localparam int unsigned MmioSelBit = 31;

   localparam logic [3:0] OffCycle    = 4'd0;
   localparam logic [3:0] OffLed      = 4'd1;
   localparam logic [3:0] OffTxData   = 4'd2;
   localparam logic [3:0] OffTxStatus = 4'd3;

   localparam int unsigned StatEmptyBit = 0;
   localparam int unsigned StatFullBit  = 1;
   localparam int unsigned StatOvfBit   = 2;
   localparam int unsigned StatCountLsb = 8;

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// Processor dmem port plus the TX byte stream toward the external serializer.
interface dmem_mmio_responder_if;

   logic [31:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q_dmem;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;

   // master: processor and serializer side; slave: the responder
   modport master (
      output address_dmem, data, wren, tx_ready,
      input  q_dmem, tx_valid, tx_data
   );

   modport slave (
      input  address_dmem, data, wren, tx_ready,
      output q_dmem, tx_valid, tx_data
   );

endinterface

// File: rtl/dmem_mmio_responder_tx_byte_fifo.sv
// Synchronous byte FIFO with registered head output; a push while full is accepted only
// when a pop happens at the same edge.
module dmem_mmio_responder_tx_byte_fifo #(
   parameter int unsigned Depth = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [7:0]             wdata,
   output logic [7:0]             rdata,
   output logic [$clog2(Depth):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned PtrW = $clog2(Depth);

   logic [7:0]      mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]   count_q;
   logic            push_ok, pop_ok;

   assign full    = (count_q == (PtrW + 1)'(Depth));
   assign empty   = (count_q == '0);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
         else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
      end
   end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM in the low half of the address space, MMIO cycle counter,
// LED register and TX byte FIFO in the high half. Read data is registered, read-first.
module dmem_mmio_responder
   import dmem_mmio_responder_pkg::*;
#(
   parameter int unsigned ADDR_BITS  = 12,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned LED_WIDTH  = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   dmem_mmio_responder_if.slave bus,
   output logic [LED_WIDTH-1:0] led_out
);

   logic [31:0]                ram [2**ADDR_BITS];
   logic [31:0]                cycle_q, q_dmem_q, rd_val, status;
   logic [LED_WIDTH-1:0]       led_q;
   logic                       ovf_q;
   logic                       is_mmio;
   logic [3:0]                 offset;
   logic [ADDR_BITS-1:0]       ram_idx;
   logic                       push_req, status_wr, pop;
   logic                       fifo_full, fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                       unused_addr;

   assign is_mmio     = bus.address_dmem[MmioSelBit];
   assign offset      = bus.address_dmem[3:0];
   assign ram_idx     = bus.address_dmem[ADDR_BITS-1:0];
   assign unused_addr = ^bus.address_dmem[30:ADDR_BITS];

   assign push_req  = bus.wren & is_mmio & (offset == OffTxData);
   assign status_wr = bus.wren & is_mmio & (offset == OffTxStatus);
   assign pop       = ~fifo_empty & bus.tx_ready;

   dmem_mmio_responder_tx_byte_fifo #(
      .Depth (FIFO_DEPTH)
   ) u_tx_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push_req),
      .pop   (pop),
      .wdata (bus.data[7:0]),
      .rdata (bus.tx_data),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.tx_valid = ~fifo_empty;
   assign bus.q_dmem   = q_dmem_q;
   assign led_out      = led_q;

   always_comb begin
      status                         = '0;
      status[StatEmptyBit]           = fifo_empty;
      status[StatFullBit]            = fifo_full;
      status[StatOvfBit]             = ovf_q;
      status[StatCountLsb +: 8]      = 8'(fifo_count);
   end

   // Sampled before this edge's updates, which gives read-first behaviour everywhere.
   always_comb begin
      rd_val = '0;
      if (!is_mmio) begin
         rd_val = ram[ram_idx];
      end else begin
         case (offset)
            OffCycle:    rd_val = cycle_q;
            OffLed:      rd_val[LED_WIDTH-1:0] = led_q;
            OffTxStatus: rd_val = status;
            default:     rd_val = '0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (bus.wren && !is_mmio) ram[ram_idx] <= bus.data;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cycle_q  <= '0;
         led_q    <= '0;
         ovf_q    <= 1'b0;
         q_dmem_q <= '0;
      end else begin
         cycle_q  <= cycle_q + 32'd1;
         q_dmem_q <= rd_val;
         if (bus.wren && is_mmio && offset == OffLed) led_q <= bus.data[LED_WIDTH-1:0];
         // Status write beats a simultaneous dropping push.
         if (status_wr)                         ovf_q <= 1'b0;
         else if (push_req && fifo_full && !pop) ovf_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: RAM, LED, TX FIFO, cycle counter and async reset.
module tb_dmem_mmio_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] led_out;
   int          vectors = 0;
   int          miscompares = 0;

   dmem_mmio_responder_if bus ();

   dmem_mmio_responder #(
      .ADDR_BITS  (12),
      .FIFO_DEPTH (8),
      .LED_WIDTH  (16)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .bus     (bus.slave),
      .led_out (led_out)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One bus transaction: drive at the falling edge, return 1 time unit after the rising edge.
   task automatic bus_op(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                         input logic rdy);
      @(negedge clock);
      bus.address_dmem = addr;
      bus.data         = wdata;
      bus.wren         = we;
      bus.tx_ready     = rdy;
      @(posedge clock);
      #1;
      bus.wren     = 1'b0;
      bus.tx_ready = 1'b0;
   endtask

   initial begin
      bus.address_dmem = 32'h8000_0000;
      bus.data         = '0;
      bus.wren         = 1'b0;
      bus.tx_ready     = 1'b0;

      #2;
      chk("rst_q_dmem", bus.q_dmem, 32'h0);
      chk("rst_led", {16'h0, led_out}, 32'h0);
      chk("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
      chk("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);

      // Cycle counter: 10th edge after release reports 9
      @(negedge clock);
      reset = 1'b1;
      repeat (10) @(posedge clock);
      #1;
      chk("cycle_at_10", bus.q_dmem, 32'd9);

      // RAM write/read and aliasing
      bus_op(32'h0000_0005, 32'hDEAD_BEEF, 1'b1, 1'b0);
      bus_op(32'h0000_0005, 32'h0, 1'b0, 1'b0);
      chk("ram_rd5", bus.q_dmem, 32'hDEAD_BEEF);
      bus_op(32'h0000_1005, 32'h0, 1'b0, 1'b0);
      chk("ram_alias", bus.q_dmem, 32'hDEAD_BEEF);

      // Read-during-write returns old word
      bus_op(32'h0000_0007, 32'h1111_1111, 1'b1, 1'b0);
      bus_op(32'h0000_0007, 32'h2222_2222, 1'b1, 1'b0);
      chk("ram_rdw_old", bus.q_dmem, 32'h1111_1111);
      bus_op(32'h0000_0007, 32'h0, 1'b0, 1'b0);
      chk("ram_rdw_new", bus.q_dmem, 32'h2222_2222);

      // LED register
      bus_op(32'h8000_0001, 32'h0001_ABCD, 1'b1, 1'b0);
      chk("led_out", {16'h0, led_out}, 32'h0000_ABCD);
      bus_op(32'h8000_0001, 32'h0, 1'b0, 1'b0);
      chk("led_read", bus.q_dmem, 32'h0000_ABCD);
      bus_op(32'h8000_000F, 32'h0, 1'b0, 1'b0);
      chk("unmapped_read", bus.q_dmem, 32'h0);
      bus_op(32'h8000_0002, 32'h0, 1'b0, 1'b0);
      chk("txdata_read", bus.q_dmem, 32'h0);

      // FIFO fill with overflow
      bus_op(32'h8000_0002, 32'h41, 1'b1, 1'b0);
      chk("tx_valid_first", {31'h0, bus.tx_valid}, 32'h1);
      chk("tx_data_first", {24'h0, bus.tx_data}, 32'h41);
      for (int i = 1; i < 9; i++) bus_op(32'h8000_0002, 32'h41 + i, 1'b1, 1'b0);
      bus_op(32'h8000_0003, 32'h0, 1'b0, 1'b0);
      chk("status_full_ovf", bus.q_dmem, 32'h0000_0806);

      // Drain
      @(negedge clock);
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("drain1_valid", {31'h0, bus.tx_valid}, 32'h1);
         chk("drain1_data", {24'h0, bus.tx_data}, 32'h41 + i);
         @(posedge clock);
         #1;
      end
      bus.tx_ready = 1'b0;
      chk("drain1_empty_valid", {31'h0, bus.tx_valid}, 32'h0);
      bus_op(32'h8000_0003, 32'h0, 1'b0, 1'b0);
      chk("status_empty_ovf", bus.q_dmem, 32'h0000_0005);
      bus_op(32'h8000_0003, 32'hFFFF_FFFF, 1'b1, 1'b0);
      bus_op(32'h8000_0003, 32'h0, 1'b0, 1'b0);
      chk("status_ovf_clear", bus.q_dmem, 32'h0000_0001);

      // Push and pop together while full
      for (int i = 0; i < 8; i++) bus_op(32'h8000_0002, 32'h50 + i, 1'b1, 1'b0);
      bus_op(32'h8000_0003, 32'h0, 1'b0, 1'b0);
      chk("status_full", bus.q_dmem, 32'h0000_0802);
      bus_op(32'h8000_0002, 32'h5A, 1'b1, 1'b1);
      bus_op(32'h8000_0003, 32'h0, 1'b0, 1'b0);
      chk("status_pushpop_full", bus.q_dmem, 32'h0000_0802);
      @(negedge clock);
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("drain2_data", {24'h0, bus.tx_data}, (i == 7) ? 32'h5A : 32'h51 + i);
         @(posedge clock);
         #1;
      end
      bus.tx_ready = 1'b0;
      chk("drain2_empty_valid", {31'h0, bus.tx_valid}, 32'h0);

      // Asynchronous reset mid-cycle with bytes queued
      for (int i = 0; i < 3; i++) bus_op(32'h8000_0002, 32'h60 + i, 1'b1, 1'b0);
      bus_op(32'h8000_0001, 32'h0, 1'b0, 1'b0);
      chk("pre_rst_q", bus.q_dmem, 32'h0000_ABCD);
      chk("pre_rst_valid", {31'h0, bus.tx_valid}, 32'h1);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_valid", {31'h0, bus.tx_valid}, 32'h0);
      chk("async_rst_led", {16'h0, led_out}, 32'h0);
      chk("async_rst_q", bus.q_dmem, 32'h0);
      chk("async_rst_txdata", {24'h0, bus.tx_data}, 32'h0);
      @(negedge clock);
      reset = 1'b1;
      bus_op(32'h8000_0003, 32'h0, 1'b0, 1'b0);
      chk("post_rst_status", bus.q_dmem, 32'h0000_0001);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
